// File: rtl/scan_crypt_pkg.sv
// Shared types and sizing helpers for the scan encryption sequencing controller.
package scan_crypt_pkg;

    localparam int unsigned DEFAULT_DATA_W = 128;

    // Counter holds 0..DATA_W-1 with one spare bit of headroom.
    function automatic int unsigned cnt_w(input int unsigned data_w);
        return $clog2(data_w) + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_START,
        ST_WAIT,
        ST_LOAD,
        ST_SHIFT_OUT
    } scan_crypt_state_t;

endpackage

// File: rtl/scan_bit_counter.sv
// Scan bit counter shared by the capture and unload phases; wraps to 0 on the last bit of a block.
module scan_bit_counter
    import scan_crypt_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = cnt_w(DATA_W)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_crypt_ctrl.sv
// Scan encryption path sequencer: capture, encrypt, unload.
// Define SCAN_CRYPT_TIMEOUT_EN to build the encryption watchdog that drives err.
module scan_crypt_ctrl
    import scan_crypt_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scan_en,
    input  logic enc_done,
    output logic sipo_shift_en,
    output logic enc_start,
    output logic enc_en,
    output logic piso_load,
    output logic piso_shift_en,
    output logic busy,
    output logic frame_done,
    output logic err
);

    localparam int unsigned CNT_W = cnt_w(DATA_W);

    if (DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("scan_crypt_ctrl: DATA_W and TIMEOUT_CYC must be at least 1");
    end

    scan_crypt_state_t state_q, state_d;
    logic              last_bit;
    logic              in_enc;
    logic              wd_expired;
    logic              frame_done_q;

    scan_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (sipo_shift_en | piso_shift_en),
        .last    (last_bit)
    );

    assign in_enc = (state_q == ST_START) || (state_q == ST_WAIT);

`ifdef SCAN_CRYPT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Expiry on the TIMEOUT_CYC-th cycle of START+WAIT; a coincident enc_done still wins.
    assign wd_expired = in_enc && !enc_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign err        = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= in_enc ? wd_cnt + 1'b1 : '0;
            if (wd_expired) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == ST_SHIFT_OUT) && scan_en && last_bit;
        end
    end

    always_comb begin
        state_d       = state_q;
        sipo_shift_en = 1'b0;
        piso_shift_en = 1'b0;
        enc_start     = 1'b0;
        enc_en        = 1'b0;
        piso_load     = 1'b0;
        busy          = 1'b0;
        case (state_q)
            // Counter sits at 0 in IDLE, so last_bit here only occurs for one-bit blocks.
            ST_IDLE: begin
                sipo_shift_en = scan_en;
                if (scan_en) begin
                    state_d = last_bit ? ST_START : ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                sipo_shift_en = scan_en;
                if (scan_en && last_bit) begin
                    state_d = ST_START;
                end
            end
            ST_START, ST_WAIT: begin
                enc_start = (state_q == ST_START);
                enc_en    = 1'b1;
                busy      = 1'b1;
                if (enc_done) begin
                    state_d = ST_LOAD;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_LOAD: begin
                piso_load = 1'b1;
                busy      = 1'b1;
                state_d   = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                piso_shift_en = scan_en;
                if (scan_en && last_bit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_crypt_ctrl.sv
// Self-checking bench for scan_crypt_ctrl: frame scoreboard plus reset, watchdog and back-to-back cases.
module tb_scan_crypt_ctrl;

    localparam int DW = 128;
    localparam int TO = 64;

    logic clk;
    logic reset_n;
    logic scan_en;
    logic enc_done;
    logic sipo_shift_en;
    logic enc_start;
    logic enc_en;
    logic piso_load;
    logic piso_shift_en;
    logic busy;
    logic frame_done;
    logic err;

    scan_crypt_ctrl #(
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .scan_en       (scan_en),
        .enc_done      (enc_done),
        .sipo_shift_en (sipo_shift_en),
        .enc_start     (enc_start),
        .enc_en        (enc_en),
        .piso_load     (piso_load),
        .piso_shift_en (piso_shift_en),
        .busy          (busy),
        .frame_done    (frame_done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n_in;
        int n_out;
        int len;
    } frame_exp_t;

    frame_exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-frame observation, restarted at every frame_done and while in reset.
    int cyc = 0;
    int n_sipo, n_piso, n_start, n_load, viol;
    int first_sipo, last_sipo, first_piso, last_piso, start_c, done_c, load_c;
    bit done_seen;

    task automatic clear_acc();
        n_sipo = 0; n_piso = 0; n_start = 0; n_load = 0; viol = 0;
        first_sipo = 0; last_sipo = 0; first_piso = 0; last_piso = 0;
        start_c = 0; done_c = 0; load_c = 0; done_seen = 1'b0;
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        frame_exp_t e;
        cyc++;
        if (!reset_n) begin
            clear_acc();
        end else begin
            if (frame_done) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("n_sipo", n_sipo, e.n_in);
                    check("n_piso", n_piso, e.n_out);
                    check("n_start", n_start, 1);
                    check("n_load", n_load, 1);
                    check("start_gap", start_c - last_sipo, 1);
                    check("load_gap", load_c - done_c, 1);
                    check("first_out", int'(first_piso > load_c), 1);
                    check("fd_gap", cyc - last_piso, 1);
                    check("shift_viol", viol, 0);
                    check("fd_busy", busy, 0);
                    if (e.len != 0) check("frame_len", last_piso - first_sipo + 1, e.len);
                end
                clear_acc();
            end
            if (sipo_shift_en) begin
                if (n_sipo == 0) first_sipo = cyc;
                n_sipo++;
                last_sipo = cyc;
            end
            if (piso_shift_en) begin
                if (n_piso == 0) first_piso = cyc;
                n_piso++;
                last_piso = cyc;
            end
            if (enc_start) begin
                n_start++;
                start_c = cyc;
            end
            if (enc_done && enc_en && !done_seen) begin
                done_seen = 1'b1;
                done_c = cyc;
            end
            if (piso_load) begin
                n_load++;
                load_c = cyc;
            end
            if ((sipo_shift_en || piso_shift_en) && busy) viol++;
            if (sipo_shift_en && piso_shift_en) viol++;
        end
    end

    // Encryptor model: enc_done asserted lat_cur cycles after enc_start (never when negative).
    int lat_cur = 11;
    int since = 0;

    task automatic step(input bit se, input bit end_se, input bit glitch);
        @(posedge clk);
        #1;
        if (enc_start) since = 0;
        else if (enc_en) since++;
        enc_done = glitch || (lat_cur >= 0 && enc_en && since == lat_cur);
        scan_en  = frame_done ? end_se : se;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input bit gaps, input int lat, input bit glitch,
                             input bit b2b, input int exp_len);
        frame_exp_t e;
        bit done;
        e.n_in = DW;
        e.n_out = DW;
        e.len = exp_len;
        sb.push_back(e);
        lat_cur = lat;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            step(gaps ? (i % 2 == 0) : 1'b1, b2b, glitch && i == 30);
            if (frame_done) begin
                done = 1'b1;
                if (b2b) begin
                    #1;
                    check("b2b_sipo", sipo_shift_en, 1);
                end
            end
        end
        if (!done) begin
            check("frame_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        scan_en = 1'b0;
        enc_done = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        frame_exp_t e;
        bit hit;
        int n;

        reset_n = 1'b0;
        scan_en = 1'b1;
        enc_done = 1'b0;
        #3;
        check("rst_sipo_hi", sipo_shift_en, 1);
        check("rst_busy", busy, 0);
        check("rst_enc_en", enc_en, 0);
        check("rst_enc_start", enc_start, 0);
        check("rst_piso_load", piso_load, 0);
        check("rst_piso_shift", piso_shift_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        scan_en = 1'b0;
        #1;
        check("rst_sipo_lo", sipo_shift_en, 0);
        #19 reset_n = 1'b1;

        idle(3);
        run_frame(1'b0, 11, 1'b0, 1'b0, 2 * DW + 11 + 2);
        idle(4);
        run_frame(1'b1, 5, 1'b0, 1'b0, 0);
        idle(4);
        run_frame(1'b0, 0, 1'b1, 1'b0, 2 * DW + 0 + 2);
        idle(4);

        // Reset during output bit 60 drops the frame.
        e.n_in = DW; e.n_out = DW; e.len = 0;
        sb.push_back(e);
        lat_cur = 11;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (n_piso == 60) hit = 1'b1;
        end
        check("reach_bit60", hit, 1);
        check("pre_rst_piso", piso_shift_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_piso", piso_shift_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fd", frame_done, 0);
        check("mid_rst_sipo", sipo_shift_en, 1);
        void'(sb.pop_back());
        scan_en = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        idle(3);
        run_frame(1'b0, 11, 1'b0, 1'b1, 2 * DW + 11 + 2);
        run_frame(1'b0, 3, 1'b0, 1'b0, 2 * DW + 3 + 2);
        idle(4);

        // Encryptor that never answers.
        lat_cur = -1;
        n = 0;
        while (!enc_en && n < 400) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("hang_started", enc_en, 1);
`ifdef SCAN_CRYPT_TIMEOUT_EN
        n = 0;
        while (enc_en && n < 2000) begin
            n++;
            step(1'b0, 1'b0, 1'b0);
        end
        check("wd_cycles", n, TO);
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        idle(5);
        check("wd_no_load", n_load, 0);
        check("wd_err_sticky", err, 1);
`else
        repeat (1000) step(1'b0, 1'b0, 1'b0);
        check("hang_enc_en", enc_en, 1);
        check("hang_busy", busy, 1);
        check("hang_no_load", n_load, 0);
        check("hang_err", err, 0);
`endif
        pulse_reset();
        #1;
        check("post_rst_err", err, 0);
        check("post_rst_busy", busy, 0);
        idle(2);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_crypt_ctrl.md
# scan_crypt_ctrl

Sequencing controller for the scan encryption path: serial-to-parallel capture, 128-bit encryptor, parallel-to-serial unload. It counts incoming scan bits, starts the encryptor once a full block is captured, waits for completion, loads the unload register and counts outgoing bits. The scan wrapper sees a single `scan_en` request and a `busy` stall indication. An optional watchdog aborts a hung encryption.

## Interface
- `DATA_W`, 128, block width in bits (bits per frame in and out)
- `TIMEOUT_CYC`, 64, maximum cycles spent in START+WAIT before abort (watchdog build only)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset; asynchronous, active-low
- `scan_en`  in  1  wrapper offers/requests one scan bit this cycle
- `enc_done`  in  1  encryptor result valid (level or pulse)
- `sipo_shift_en`  out  1  shift one bit into SIPO this cycle
- `enc_start`  out  1  one-cycle start pulse to encryptor
- `enc_en`  out  1  encryptor enable, high during START and WAIT
- `piso_load`  out  1  one-cycle parallel load of PISO
- `piso_shift_en`  out  1  shift one bit out of PISO this cycle
- `busy`  out  1  high in START, WAIT, LOAD; wrapper must not count scan bits
- `frame_done`  out  1  one-cycle pulse after last output bit
- `err`  out  1  sticky; set on watchdog abort, cleared only by reset

## Operation
- FSM states: IDLE, SHIFT_IN, START, WAIT, LOAD, SHIFT_OUT. Bit counter `cnt`, width $clog2(DATA_W)+1.
- IDLE: `scan_en`=1 accepts bit 0, `cnt`←1, next SHIFT_IN. When DATA_W=1, next START instead.
- SHIFT_IN: each cycle with `scan_en`=1 accepts a bit and increments `cnt`. `scan_en`=0 pauses and holds `cnt`. Accepting bit DATA_W-1 clears `cnt` and moves to START.
- `sipo_shift_en` = `scan_en` & (state∈{IDLE, SHIFT_IN}). This is combinational.
- START lasts exactly one cycle (`enc_start`=1), then WAIT. `enc_done` sampled high in START or WAIT moves to LOAD.
- LOAD lasts exactly one cycle (`piso_load`=1), then SHIFT_OUT.
- SHIFT_OUT: `piso_shift_en` = `scan_en`. Each such cycle increments `cnt`. Shifting bit DATA_W-1 clears `cnt` and moves to IDLE, and `frame_done` is registered high for the next cycle.
- `scan_en` during START, WAIT or LOAD is ignored; no bit is counted.
- `enc_done` outside START/WAIT is ignored.
- `sipo_shift_en`, `piso_shift_en` and `busy` are all decoded from state and `scan_en`. `sipo_shift_en` and `piso_shift_en` are never both high.

## Timing
- Reset values: state IDLE, `cnt`=0. All outputs 0 except the combinational `sipo_shift_en`, which follows `scan_en`. `err`=0.
- Last input bit accepted in cycle N: `enc_start` high in N+1, WAIT from N+2.
- `enc_done` high in cycle M: `piso_load` high in M+1. First output bit can shift in M+2.
- Minimum frame with encryptor latency L (done L cycles after start): 2·DATA_W+L+2 cycles.
- Last output bit in cycle K: `frame_done` high in K+1 with state IDLE. `scan_en` in K+1 starts a new frame in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE, `cnt`=0, all pulses dropped, partial frame discarded.

## Configuration
- `SCAN_CRYPT_TIMEOUT_EN` defined: a watchdog counts cycles in START+WAIT. When it reaches TIMEOUT_CYC without `enc_done`, the FSM returns to IDLE, sets `err`, and does not pulse `piso_load` or `frame_done`.
- `SCAN_CRYPT_TIMEOUT_EN` undefined: WAIT is unbounded, `err` is tied 0, and TIMEOUT_CYC is unused.

## Structure
- Shared package `scan_crypt_pkg`: state enum `scan_crypt_state_t`, default DATA_W constant, and CNT_W function/constant.
- One sub-module `scan_bit_counter` holds the increment/clear/terminal-count logic, shared by the SHIFT_IN and SHIFT_OUT phases. The FSM and watchdog live in the top module.

## Test plan
- Full frame: `scan_en` held 128 cycles, `enc_done` 11 cycles after `enc_start`. Expect exactly 128 `sipo_shift_en`, one `enc_start`, one `piso_load`, 128 `piso_shift_en`, then `frame_done` one cycle after the last shift.
- Gaps: `scan_en` toggling 1/0 during both shift phases. Expect counts to hold during 0s, still exactly 128 shifts each way, and no shift pulses while `busy`.
- `enc_done` high in the START cycle: expect `piso_load` in the next cycle. `enc_done` pulsed in SHIFT_IN: expect it to be ignored.
- Watchdog build, `enc_done` never asserted: after 64 cycles expect IDLE, `err`=1, and no `piso_load`. Non-watchdog build: still WAIT after 1000 cycles.
- `reset_n` low at output bit 60: expect IDLE and outputs 0 asynchronously. The next frame must then run 128/128 bits correctly.
- Back-to-back: `scan_en` high in the `frame_done` cycle. Expect `sipo_shift_en`=1 in that cycle and a second full frame with correct counts.
